// File: rtl/kbd_scan_ctrl_if.sv
// Keyboard port bundle: PS/2 byte input plus the processor-side FIFO port.
// The master drives scan bytes and read/clear strobes; the slave is kbd_scan_ctrl.
interface kbd_scan_ctrl_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]    scan_code;
  logic          scan_valid;
  logic          rd_en;
  logic          clr_ovf;
  logic [7:0]    ascii_out;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic          shift_held;

  modport master (
    output scan_code, scan_valid, rd_en, clr_ovf,
    input  ascii_out, empty, full, count, overflow, shift_held
  );

  modport slave (
    input  scan_code, scan_valid, rd_en, clr_ovf,
    output ascii_out, empty, full, count, overflow, shift_held
  );
endinterface

// File: rtl/kbd_scan_ctrl.sv
// PS/2 set-2 scan-code sequencer: prefix FSM, shift tracking, key2ascii lookup, show-ahead FIFO.
// Optional macro LOWERCASE_EN: unshifted letters are pushed as lowercase.

module key2ascii (
  input  logic [7:0] code,
  output logic [7:0] ascii
);
  // 8'h2A marks "no printable mapping"; the caller drops it.
  always_comb begin
    ascii = 8'h2A;
    case (code)
      8'h1C: ascii = 8'h41;  8'h32: ascii = 8'h42;  8'h21: ascii = 8'h43;
      8'h23: ascii = 8'h44;  8'h24: ascii = 8'h45;  8'h2B: ascii = 8'h46;
      8'h34: ascii = 8'h47;  8'h33: ascii = 8'h48;  8'h43: ascii = 8'h49;
      8'h3B: ascii = 8'h4A;  8'h42: ascii = 8'h4B;  8'h4B: ascii = 8'h4C;
      8'h3A: ascii = 8'h4D;  8'h31: ascii = 8'h4E;  8'h44: ascii = 8'h4F;
      8'h4D: ascii = 8'h50;  8'h15: ascii = 8'h51;  8'h2D: ascii = 8'h52;
      8'h1B: ascii = 8'h53;  8'h2C: ascii = 8'h54;  8'h3C: ascii = 8'h55;
      8'h2A: ascii = 8'h56;  8'h1D: ascii = 8'h57;  8'h22: ascii = 8'h58;
      8'h35: ascii = 8'h59;  8'h1A: ascii = 8'h5A;
      8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;  8'h5A: ascii = 8'h0D;  8'h66: ascii = 8'h08;
      default: ascii = 8'h2A;
    endcase
  end
endmodule

module kbd_scan_ctrl #(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic          clk,
  input logic          rst,
  kbd_scan_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          shift_q, shift_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic [7:0] lut_ascii;
  logic [7:0] push_char;
  logic       push_req;
  logic       tmo_hit;
  logic       is_shift;
  logic       is_ignored;
  logic       fifo_full;
  logic       fifo_empty;
  logic       do_push;
  logic       do_pop;
  logic       ovf_set;

  key2ascii u_key2ascii (
    .code  (bus.scan_code),
    .ascii (lut_ascii)
  );

  assign is_shift   = (bus.scan_code == 8'h12) || (bus.scan_code == 8'h59);
  assign is_ignored = (bus.scan_code == 8'hAA) || (bus.scan_code == 8'hFA) ||
                      (bus.scan_code == 8'hFE) || (bus.scan_code == 8'hEE) ||
                      (bus.scan_code == 8'h00) || (bus.scan_code == 8'hFF);
  assign tmo_hit    = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES));

  always_comb begin
    push_char = lut_ascii;
`ifdef LOWERCASE_EN
    if (!shift_q && (lut_ascii >= 8'h41) && (lut_ascii <= 8'h5A)) begin
      push_char = lut_ascii + 8'h20;
    end
`endif
  end

  // Prefix FSM: only scan_valid moves it, except the stale-prefix timeout.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    if (bus.scan_valid) begin
      case (state_q)
        IDLE: begin
          if (bus.scan_code == 8'hF0) begin
            state_d = BRK;
          end else if (bus.scan_code == 8'hE0) begin
            state_d = EXT;
          end else if (is_shift) begin
            shift_d = 1'b1;
          end else if (!is_ignored && (lut_ascii != 8'h2A)) begin
            push_req = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (is_shift) begin
            shift_d = 1'b0;
          end
        end
        EXT: begin
          state_d = (bus.scan_code == 8'hF0) ? EXT_BRK : IDLE;
        end
        EXT_BRK: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end else if (tmo_hit) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    tmo_d = tmo_q + 1'b1;
    if (bus.scan_valid || (state_q == IDLE) || tmo_hit) begin
      tmo_d = '0;
    end
  end

  // A pop in the same cycle frees the slot, so a push onto a full FIFO still lands.
  always_comb begin
    fifo_full  = (count_q == CW'(DEPTH));
    fifo_empty = (count_q == '0);
    do_pop     = bus.rd_en && !fifo_empty;
    do_push    = push_req && (!fifo_full || do_pop);
    ovf_set    = push_req && fifo_full && !do_pop;

    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;

    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tmo_q      <= '0;
      shift_q    <= 1'b0;
      overflow_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      overflow_q <= overflow_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_char;
    end
  end

  assign bus.ascii_out  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  assign bus.empty      = fifo_empty;
  assign bus.full       = fifo_full;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
  assign bus.shift_held = shift_q;

endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// Directed bench for kbd_scan_ctrl (DEPTH=4, short timeout); honours LOWERCASE_EN.
module tb_kbd_scan_ctrl;
  localparam int DEPTH = 4;
  localparam int TMO   = 100;

`ifdef LOWERCASE_EN
  localparam logic [7:0] CHAR_A = 8'h61;
`else
  localparam logic [7:0] CHAR_A = 8'h41;
`endif

  logic clk;
  logic rst;
  int   checks_cnt;
  int   errors_cnt;

  kbd_scan_ctrl_if #(.DEPTH(DEPTH)) bus ();

  kbd_scan_ctrl #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %-16s got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %-16s value=%0h", tag, got);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.scan_code  = b;
    bus.scan_valid = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
  endtask

  task automatic fill_digits();
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25);
  endtask

  initial begin
    logic [7:0] heads [4];
    checks_cnt     = 0;
    errors_cnt     = 0;
    rst            = 1'b1;
    bus.scan_code  = 8'h00;
    bus.scan_valid = 1'b0;
    bus.rd_en      = 1'b0;
    bus.clr_ovf    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_ascii", 32'(bus.ascii_out), 0);
    check("rst_ovf", 32'(bus.overflow), 0);
    check("rst_shift", 32'(bus.shift_held), 0);

    // Single make code, then pop
    send(8'h1C);
    check("a_empty", 32'(bus.empty), 0);
    check("a_count", 32'(bus.count), 1);
    check("a_ascii", 32'(bus.ascii_out), 32'(CHAR_A));
    pop();
    check("a_pop_empty", 32'(bus.empty), 1);
    check("a_pop_ascii", 32'(bus.ascii_out), 0);

    // Break and extended sequences push nothing
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    check("prefix_count", 32'(bus.count), 0);
    send(8'h5A);
    check("cr_count", 32'(bus.count), 1);
    check("cr_ascii", 32'(bus.ascii_out), 32'h0D);
    pop();

    // Ignored bytes and unmapped code
    send(8'hAA); send(8'hFA); send(8'hFF); send(8'h0E);
    check("ignored_count", 32'(bus.count), 0);

    // Fill to full and drain in order
    fill_digits();
    check("fill_full", 32'(bus.full), 1);
    check("fill_count", 32'(bus.count), 4);
    heads[0] = 8'h31; heads[1] = 8'h32; heads[2] = 8'h33; heads[3] = 8'h34;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain1_%0d", i), 32'(bus.ascii_out), 32'(heads[i]));
      pop();
    end
    check("drain1_empty", 32'(bus.empty), 1);

    // Overflow on push while full
    fill_digits();
    send(8'h2E);
    check("ovf_set", 32'(bus.overflow), 1);
    check("ovf_count", 32'(bus.count), 4);
    check("ovf_head", 32'(bus.ascii_out), 32'h31);
    clear_ovf();
    check("ovf_clr", 32'(bus.overflow), 0);
    // Set wins over clear in the same cycle
    @(negedge clk);
    bus.scan_code  = 8'h2E;
    bus.scan_valid = 1'b1;
    bus.clr_ovf    = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.clr_ovf    = 1'b0;
    check("ovf_set_wins", 32'(bus.overflow), 1);
    clear_ovf();
    check("ovf_clr2", 32'(bus.overflow), 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain2_%0d", i), 32'(bus.ascii_out), 32'(heads[i]));
      pop();
    end
    check("drain2_empty", 32'(bus.empty), 1);

    // Push and pop together while full
    fill_digits();
    @(negedge clk);
    bus.scan_code  = 8'h45;
    bus.scan_valid = 1'b1;
    bus.rd_en      = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.rd_en      = 1'b0;
    check("pp_count", 32'(bus.count), 4);
    check("pp_ovf", 32'(bus.overflow), 0);
    heads[0] = 8'h32; heads[1] = 8'h33; heads[2] = 8'h34; heads[3] = 8'h30;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain3_%0d", i), 32'(bus.ascii_out), 32'(heads[i]));
      pop();
    end

    // Pop on empty with a push in the same cycle
    @(negedge clk);
    bus.scan_code  = 8'h16;
    bus.scan_valid = 1'b1;
    bus.rd_en      = 1'b1;
    @(negedge clk);
    bus.scan_valid = 1'b0;
    bus.rd_en      = 1'b0;
    check("epp_count", 32'(bus.count), 1);
    check("epp_ascii", 32'(bus.ascii_out), 32'h31);
    pop();

    // Break prefix within the timeout swallows the next byte
    send(8'hF0);
    repeat (10) @(negedge clk);
    send(8'h1C);
    check("brk_swallow", 32'(bus.count), 0);

    // Break prefix past the timeout is abandoned
    send(8'hF0);
    repeat (TMO + 2) @(negedge clk);
    send(8'h1C);
    check("tmo_count", 32'(bus.count), 1);
    check("tmo_ascii", 32'(bus.ascii_out), 32'(CHAR_A));
    pop();

    // Shift tracking
    send(8'h12); send(8'h1C);
    check("shift_held", 32'(bus.shift_held), 1);
    check("shift_ascii", 32'(bus.ascii_out), 32'h41);
    pop();
    send(8'h16);
    check("shift_digit", 32'(bus.ascii_out), 32'h31);
    pop();
    send(8'hF0); send(8'h12);
    check("shift_rel", 32'(bus.shift_held), 0);
    send(8'h1C);
    check("unshift_ascii", 32'(bus.ascii_out), 32'(CHAR_A));
    pop();
    send(8'h59);
    check("rshift_held", 32'(bus.shift_held), 1);
    send(8'hF0); send(8'h59);
    check("rshift_rel", 32'(bus.shift_held), 0);

    // Reset mid-sequence drops the prefix and buffered data
    send(8'h1C); send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_count", 32'(bus.count), 0);
    send(8'h1C);
    check("mrst_push", 32'(bus.count), 1);
    check("mrst_ascii", 32'(bus.ascii_out), 32'(CHAR_A));

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end
endmodule

// File: doc/kbd_scan_ctrl.md
Name: kbd_scan_ctrl

Overview:
Sequences PS/2 set-2 scan-code bytes from the keyboard receiver into ASCII characters for the processor.
- Tracks make, break (F0) and extended (E0) prefixes, and the shift state.
- Feeds make codes to an internal key2ascii instance.
- Buffers recognised characters in a show-ahead FIFO that the processor drains with a read strobe.
- Sits between the PS/2 byte receiver and the processor's memory-mapped keyboard port.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, at least 2.
TIMEOUT_CYCLES, 50000, idle clock cycles allowed in a prefix state before the FSM returns to IDLE (1 ms at 50 MHz).

Ports:
clk  in  1  system clock; all logic on its rising edge.
rst  in  1  synchronous, active-high reset.
scan_code  in  8  byte from the PS/2 receiver.
scan_valid  in  1  one-cycle strobe; scan_code is valid in this cycle.
rd_en  in  1  pops the FIFO head; ignored when empty.
clr_ovf  in  1  clears overflow.
ascii_out  out  8  FIFO head (show-ahead); 8'h00 when empty.
empty  out  1  FIFO holds 0 entries.
full  out  1  FIFO holds DEPTH entries.
count  out  $clog2(DEPTH+1)  current FIFO occupancy.
overflow  out  1  sticky flag; a character was dropped.
shift_held  out  1  left or right shift is currently pressed.

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous and active-high.
- Reset values: FSM=IDLE, timeout counter=0, count=0, empty=1, full=0, ascii_out=8'h00, overflow=0, shift_held=0. FIFO contents are don't-care. rst asserted mid-sequence discards any pending prefix and all buffered characters.
- FSM states: IDLE, BRK, EXT, EXT_BRK. State transitions happen only on scan_valid, except for timeout.
- IDLE transitions:
  - F0 -> BRK.
  - E0 -> EXT.
  - 12 or 59 -> shift_held=1, no push.
  - AA, FA, FE, EE, 00, FF -> ignored, no push.
  - Any other byte -> key2ascii lookup. If the result is not 8'h2A, push it; otherwise drop it silently.
  - Typematic repeats push on every make.
- BRK: the next byte returns the FSM to IDLE with no push. If that byte is 12 or 59, shift_held=0.
- EXT: F0 -> EXT_BRK; any other byte -> IDLE with no push. Extended keys are never emitted, including keypad Enter (E0 5A).
- EXT_BRK: any byte -> IDLE with no push.
- Timeout:
  - The counter clears on every scan_valid and whenever the FSM is in IDLE.
  - In a non-IDLE state it increments each cycle without scan_valid.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE on the next edge.
  - The following byte is treated as a fresh IDLE byte.
- Push latency: a make code on scan_valid at edge N gives the character written at edge N; empty=0 and the updated ascii_out/count are visible after that edge (1 cycle).
- Pop: rd_en with empty=0 advances the read pointer at the edge; the next entry appears on ascii_out in the following cycle.
- Simultaneous push and pop:
  - Count is not full: both occur and count is unchanged.
  - Count is full: the pop frees a slot, the push succeeds, and there is no overflow.
  - Count is empty: rd_en is ignored and the push occurs.
- Push while full with no pop: the character is dropped, FIFO contents are untouched, and overflow=1 from the next cycle.
- overflow clears on clr_ovf. If clr_ovf and a new overflow coincide, set wins.
- Pointers are log2(DEPTH) bits and wrap naturally. full is derived as count==DEPTH.

Optional Feature:
LOWERCASE_EN
- Defined: when shift_held=0, key2ascii results in 8'h41–8'h5A have 8'h20 added before the push (lowercase). With shift_held=1 they pass unchanged. Digits, space, CR and backspace are always unchanged.
- Not defined: every letter is pushed as uppercase, exactly as key2ascii returns it, and shift_held is still tracked and output.

Test Plan:
- Reset, then scan 1C -> one cycle later empty=0, count=1, ascii_out=41. Pulse rd_en -> empty=1, ascii_out=00.
- Scan F0 1C, then E0 5A, then E0 F0 5A -> count stays 0 and the FSM ends in IDLE. A following 5A pushes 0D.
- DEPTH=4: scan 16 1E 26 25 -> full=1, heads read 31,32,33,34 in order. Refill 4, then scan 2E -> overflow=1, count=4, 35 absent. clr_ovf -> overflow=0.
- Full FIFO, then rd_en and scan 45 in the same cycle -> count stays 4, overflow=0. After draining, the last entry is 30.
- Scan F0, then wait TIMEOUT_CYCLES+2 idle cycles, then scan 1C -> 41 pushed (not swallowed as a break byte).
- LOWERCASE_EN defined:
  - 1C -> 61.
  - 12 1C -> 41, shift_held=1.
  - 12 F0 12 1C -> 61, shift_held=0.
  - 16 -> 31 in all cases.
- LOWERCASE_EN undefined: every sequence above pushes 41.
